// File: rtl/dot_product_engine.sv
// Streaming signed dot-product engine: NUM_LANES multipliers, adder tree, and accumulator.
// Each window is vec_len beats long. The pipeline has three stages: product, lane sum, accumulate.
// Optional feature: define DOT_PRODUCT_SAT_EN to enable a saturating accumulator with a sticky
// overflow flag. Without it, the accumulator wraps modulo 2^ACC_W and overflow is held at 0.
module dot_product_engine #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned LEN_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [LEN_W-1:0]              vec_len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_LANES*DATA_W-1:0]   a,
    input  logic [NUM_LANES*DATA_W-1:0]   b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [ACC_W-1:0]       dot_out,
    output logic                          overflow,
    output logic                          busy
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned TREE_W = PROD_W + $clog2(NUM_LANES);
    // Lane sum is never narrower than the full tree growth, so stage 2 itself cannot overflow
    localparam int unsigned SUM_W  = (TREE_W > ACC_W) ? TREE_W : ACC_W;
    localparam int unsigned ADD_W  = SUM_W + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                    state;
    state_t                    state_next;
    logic                      clear_c;
    logic                      accept_c;
    logic                      last_beat_c;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          beat_cnt;

    logic signed [PROD_W-1:0]  prod_c [NUM_LANES];
    logic signed [PROD_W-1:0]  prod_q [NUM_LANES];
    logic                      s1_valid;
    logic signed [SUM_W-1:0]   tree_c;
    logic signed [SUM_W-1:0]   s2_sum;
    logic                      s2_valid;
    logic signed [ACC_W-1:0]   acc_next_c;
    logic                      ovf_hit_c;

    // Handshake qualifiers for the beat stream
    always_comb begin
        accept_c    = in_valid && in_ready;
        last_beat_c = (beat_cnt == (len_q - LEN_W'(1)));
    end

    // Next-state logic; DRAIN waits for the pipeline to empty before presenting the result
    always_comb begin
        state_next = state;
        clear_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear_c    = 1'b1;
                    state_next = (vec_len == '0) ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (accept_c && last_beat_c) state_next = DRAIN;
            end
            DRAIN: begin
                if (!s1_valid && !s2_valid) state_next = DONE;
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register with registered status outputs decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == ACCUM);
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

    // Window length capture and accepted-beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            beat_cnt <= '0;
        end else if (clear_c) begin
            len_q    <= vec_len;
            beat_cnt <= '0;
        end else if (accept_c) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
        end
    end

    // Stage 1 combinational: per-lane signed products
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            prod_c[i] = PROD_W'($signed(a[i*DATA_W +: DATA_W])) *
                        PROD_W'($signed(b[i*DATA_W +: DATA_W]));
        end
    end

    // Stage 1 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) prod_q[i] <= '0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                for (int i = 0; i < NUM_LANES; i++) prod_q[i] <= prod_c[i];
            end
        end
    end

    // Stage 2 combinational: sign-extended lane sum
    always_comb begin
        tree_c = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            tree_c = tree_c + SUM_W'(prod_q[i]);
        end
    end

    // Stage 2 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_sum <= tree_c;
        end
    end

    // Stage 3 combinational: accumulate with saturation or wrap
`ifdef DOT_PRODUCT_SAT_EN
    logic signed [ADD_W-1:0] sum_ext_c;
    always_comb begin
        sum_ext_c  = ADD_W'(dot_out) + ADD_W'(s2_sum);
        acc_next_c = ACC_W'(sum_ext_c);
        ovf_hit_c  = 1'b0;
        if (sum_ext_c > ADD_W'(ACC_MAX)) begin
            acc_next_c = ACC_MAX;
            ovf_hit_c  = 1'b1;
        end else if (sum_ext_c < ADD_W'(ACC_MIN)) begin
            acc_next_c = ACC_MIN;
            ovf_hit_c  = 1'b1;
        end
    end
`else
    always_comb begin
        acc_next_c = dot_out + ACC_W'(s2_sum);
        ovf_hit_c  = 1'b0;
    end
`endif

    // Stage 3 register: the accumulator drives dot_out, and overflow stays set until the next start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dot_out  <= '0;
            overflow <= 1'b0;
        end else if (clear_c) begin
            dot_out  <= '0;
            overflow <= 1'b0;
        end else if (s2_valid) begin
            dot_out  <= acc_next_c;
            overflow <= overflow | ovf_hit_c;
        end
    end

endmodule

// File: doc/dot_product_engine.md
DOT_PRODUCT_ENGINE -- requirements
Module: dot_product_engine

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, parallel multiply lanes (>=1).
REQ-002 SHALL have parameter DATA_W, default 8, signed operand width.
REQ-003 SHALL have parameter ACC_W, default 32, signed result width (>= 2*DATA_W+clog2(NUM_LANES)).
REQ-004 SHALL have parameter LEN_W, default 8, width of the beat-count field.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  begin a new window; sampled only in IDLE.
REQ-008 vec_len  input  LEN_W  beats per window, captured on accepted start.
REQ-009 in_valid  input  1  operand beat valid.
REQ-010 in_ready  output  1  engine accepts a beat.
REQ-011 a  input  NUM_LANES*DATA_W  packed signed operands; lane i at bits [i*DATA_W +: DATA_W].
REQ-012 b  input  NUM_LANES*DATA_W  packed signed operands, same packing.
REQ-013 out_valid  output  1  dot_out holds a completed result.
REQ-014 out_ready  input  1  consumer takes the result.
REQ-015 dot_out  output  ACC_W  signed dot product of the window.
REQ-016 overflow  output  1  sticky accumulation overflow flag for the window.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCUM, DRAIN, DONE.
REQ-019 IDLE + start: capture vec_len, clear accumulator and overflow; go to ACCUM, or to DRAIN if vec_len==0.
REQ-020 in_ready SHALL be high only in ACCUM; a beat is accepted on an edge where in_valid && in_ready.
REQ-021 ACCUM: count accepted beats; on acceptance of beat vec_len, go to DRAIN; in_valid low stalls without penalty.
REQ-022 Pipeline SHALL be 3 stages: per-lane signed products (2*DATA_W), registered; adder-tree lane sum, sign-extended, registered; accumulator add, registered.
REQ-023 out_valid SHALL rise exactly 3 rising edges after the edge accepting the final beat; for vec_len==0, 1 edge after start is accepted, with dot_out==0.
REQ-024 DONE: out_valid high; dot_out and overflow stable until out_valid && out_ready, then IDLE on that edge.
REQ-025 start outside IDLE SHALL be ignored, including on the DONE handshake edge.
REQ-026 vec_len changes after capture SHALL have no effect on the running window.
REQ-027 Accumulation SHALL be computed at ACC_W+1 bits; overflow condition = result outside signed ACC_W range.

Reset
REQ-028 rst high SHALL immediately force IDLE and zero every register: in_ready=0, out_valid=0, dot_out=0, overflow=0, busy=0, pipeline and beat counter cleared.
REQ-029 rst mid-window SHALL discard the window; no partial result is ever presented.

Configuration
REQ-030 With macro DOT_PRODUCT_SAT_EN defined: on overflow the accumulator SHALL clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) and set overflow (sticky until next start).
REQ-031 Without DOT_PRODUCT_SAT_EN: accumulator SHALL wrap modulo 2^ACC_W and overflow SHALL be tied 0.

Verification
REQ-032 Defaults, vec_len=2, beats a=(1,2,3,4) b=(2,3,4,5) then a=(-1,1,0,-2) b=(2,1,5,3), in_valid continuous -> dot_out=33, out_valid 3 edges after beat 2, overflow=0.
REQ-033 Same window with in_valid low 3 cycles between beats and out_ready low 5 cycles -> dot_out=33, held stable, in_ready=0 throughout DONE.
REQ-034 vec_len=0 -> out_valid one edge after start, dot_out=0, no beat accepted.
REQ-035 ACC_W=16, vec_len=1, all lanes a=b=127 -> with DOT_PRODUCT_SAT_EN dot_out=32767, overflow=1; without, dot_out=-1020, overflow=0.
REQ-036 rst pulsed after first beat of a vec_len=4 window -> all outputs 0 at once; following vec_len=2 window of REQ-032 yields 33.
REQ-037 start pulsed during ACCUM and on DONE handshake edge -> ignored; result unchanged, FSM returns to IDLE.
